// File: rtl/alu_slice_sched_pkg.sv
// ----------------------------------------------------------------------------
// alu_slice_pkg
//   Shared definitions for the ALU slice scheduler: the sequencer state
//   encoding, the field layout of the 16-bit vector presented to the external
//   4-bit ALU slice, the layout of the 5-bit vector it returns, and a helper
//   that packs one pass worth of slice input.
//
//   Slice input layout (16 bits, unused bits are zero):
//     [3:0]   A nibble
//     [7:4]   B nibble
//     [8]     carry-in
//     [11:9]  opcode
//   Slice output layout (5 bits):
//     [3:0]   result nibble
//     [4]     carry-out
// ----------------------------------------------------------------------------
package alu_slice_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam int SLICE_W       = 16;
    localparam int SLICE_OPW     = 3;

    // Slice input field positions
    localparam int SLICE_A_LSB   = 0;
    localparam int SLICE_B_LSB   = 4;
    localparam int SLICE_CIN_BIT = 8;
    localparam int SLICE_OP_LSB  = 9;

    // Slice output field positions
    localparam int SLICE_NIB_LSB  = 0;
    localparam int SLICE_COUT_BIT = 4;

    function automatic logic [SLICE_W-1:0] slice_pack(
        input logic [SLICE_OPW-1:0] op,
        input logic [3:0]           a_nib,
        input logic [3:0]           b_nib,
        input logic                 cin
    );
        logic [SLICE_W-1:0] v;
        v                              = '0;
        v[SLICE_A_LSB  +: 4]           = a_nib;
        v[SLICE_B_LSB  +: 4]           = b_nib;
        v[SLICE_CIN_BIT]               = cin;
        v[SLICE_OP_LSB +: SLICE_OPW]   = op;
        return v;
    endfunction

endpackage

// File: rtl/alu_slice_sched_if.sv
// ----------------------------------------------------------------------------
// alu_slice_sched_if
//   Request/response bundle of the ALU slice scheduler.
//     req0_* / req1_* : two valid/ready request channels (opcode, operands)
//     rsp_*           : valid/ready response channel tagged with requester id
//   Modports:
//     master : requesters and response consumer (drives requests, rsp_ready)
//     slave  : the scheduler (drives readies and the response)
// ----------------------------------------------------------------------------
interface alu_slice_sched_if #(
    parameter int NIBBLES = 4,
    parameter int OPW     = 3
);
    localparam int W = 4 * NIBBLES;

    logic           req0_valid;
    logic           req0_ready;
    logic [OPW-1:0] req0_op;
    logic [W-1:0]   req0_a;
    logic [W-1:0]   req0_b;

    logic           req1_valid;
    logic           req1_ready;
    logic [OPW-1:0] req1_op;
    logic [W-1:0]   req1_a;
    logic [W-1:0]   req1_b;

    logic           rsp_valid;
    logic           rsp_ready;
    logic           rsp_id;
    logic [W-1:0]   rsp_result;
    logic           rsp_cout;

    modport master (
        output req0_valid, req0_op, req0_a, req0_b,
        input  req0_ready,
        output req1_valid, req1_op, req1_a, req1_b,
        input  req1_ready,
        input  rsp_valid, rsp_id, rsp_result, rsp_cout,
        output rsp_ready
    );

    modport slave (
        input  req0_valid, req0_op, req0_a, req0_b,
        output req0_ready,
        input  req1_valid, req1_op, req1_a, req1_b,
        output req1_ready,
        output rsp_valid, rsp_id, rsp_result, rsp_cout,
        input  rsp_ready
    );

endinterface

// File: rtl/alu_slice_sched_rr_arb.sv
// ----------------------------------------------------------------------------
// alu_slice_rr_arb
//   Two-way round-robin arbiter. Grants are combinational and only issued
//   while 'en' is high and to a requester that is asking. On a contested
//   cycle the requester that did not win last time is granted. rr_last
//   records the winner of every grant (a grant is always a handshake, since
//   it is only given to a valid requester).
//   Ports:
//     clk, rst_n  : clock, asynchronous active-low reset
//     en          : arbitration enabled (scheduler idle)
//     req0, req1  : request valids
//     gnt0, gnt1  : one-hot grants (at most one high)
// ----------------------------------------------------------------------------
module alu_slice_rr_arb (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic req0,
    input  logic req1,
    output logic gnt0,
    output logic gnt1
);

    logic rr_last_q;

    // With both requesting, rr_last=1 favours requester 0 and vice versa.
    assign gnt0 = en & req0 & (~req1 |  rr_last_q);
    assign gnt1 = en & req1 & (~req0 | ~rr_last_q);

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values, independent of block ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_last_q <= 1'b1;
        end else if (gnt0 | gnt1) begin
            rr_last_q <= gnt1;
        end
    end

endmodule

// File: rtl/alu_slice_sched.sv
// ----------------------------------------------------------------------------
// alu_slice_sched
//   Schedules W-bit operations from two requesters onto one external 4-bit
//   ALU slice. A round-robin winner is accepted in IDLE; its operation is then
//   streamed through the slice one nibble per cycle (LSB nibble first) with
//   the carry registered between passes; the assembled result and the final
//   carry are returned on a response channel tagged with the requester id.
//   Ports:
//     clk, rst_n : clock, asynchronous active-low reset
//     bus        : request/response channels (slave side)
//     slice_in   : packed slice input, zero outside RUN
//     slice_out  : slice result nibble [3:0] and carry-out [4]
//     busy       : operation in progress (RUN or RESP)
// ----------------------------------------------------------------------------
module alu_slice_sched
    import alu_slice_pkg::*;
#(
    parameter int NIBBLES = 4,
    parameter int OPW     = 3
) (
    input  logic                clk,
    input  logic                rst_n,
    alu_slice_sched_if.slave    bus,
    output logic [SLICE_W-1:0]  slice_in,
    input  logic [4:0]          slice_out,
    output logic                busy
);

    localparam int W    = 4 * NIBBLES;
    localparam int IDXW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NIBBLES - 1);

    state_t          state_q, state_d;
    logic [OPW-1:0]  op_q;
    logic [W-1:0]    a_q;
    logic [W-1:0]    b_q;
    logic            id_q;
    logic            carry_q;
    logic [W-1:0]    result_q;
    logic [IDXW-1:0] nib_idx_q;

    logic gnt0, gnt1;
    logic accept;
    logic last_pass;

    // ------------------------------------------------------------------
    // Arbitration: only open while idle, so nothing is accepted in RUN or
    // RESP, including the cycle in which the response is taken.
    // ------------------------------------------------------------------
    alu_slice_rr_arb u_arb (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (state_q == IDLE),
        .req0  (bus.req0_valid),
        .req1  (bus.req1_valid),
        .gnt0  (gnt0),
        .gnt1  (gnt1)
    );

    assign bus.req0_ready = gnt0;
    assign bus.req1_ready = gnt1;
    assign accept         = gnt0 | gnt1;
    assign last_pass      = (nib_idx_q == LAST_IDX);

    // ------------------------------------------------------------------
    // Sequencer FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // NOTE: state_d is given its default before the case so every path
    // assigns it and no latch is inferred.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (accept)        state_d = RUN;
            RUN:  if (last_pass)     state_d = RESP;
            RESP: if (bus.rsp_ready) state_d = IDLE;
            default:                 state_d = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Operand capture and per-pass accumulation
    // ------------------------------------------------------------------
    // NOTE: the datapath registers are reset too, so the response outputs
    // and slice_in read as zero straight out of reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q      <= '0;
            a_q       <= '0;
            b_q       <= '0;
            id_q      <= 1'b0;
            carry_q   <= 1'b0;
            result_q  <= '0;
            nib_idx_q <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (accept) begin
                        op_q      <= gnt1 ? bus.req1_op : bus.req0_op;
                        a_q       <= gnt1 ? bus.req1_a  : bus.req0_a;
                        b_q       <= gnt1 ? bus.req1_b  : bus.req0_b;
                        id_q      <= gnt1;
                        carry_q   <= 1'b0;
                        nib_idx_q <= '0;
                    end
                end
                RUN: begin
                    result_q[4*nib_idx_q +: 4] <= slice_out[SLICE_NIB_LSB +: 4];
                    carry_q                    <= slice_out[SLICE_COUT_BIT];
                    // Explicit wrap keeps the index in range for any NIBBLES.
                    nib_idx_q <= last_pass ? '0 : nib_idx_q + 1'b1;
                end
                default: ;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign slice_in = (state_q == RUN)
                    ? slice_pack(SLICE_OPW'(op_q),
                                 a_q[4*nib_idx_q +: 4],
                                 b_q[4*nib_idx_q +: 4],
                                 carry_q)
                    : '0;

    assign bus.rsp_valid  = (state_q == RESP);
    assign bus.rsp_id     = id_q;
    assign bus.rsp_result = result_q;
    assign bus.rsp_cout   = carry_q;
    assign busy           = (state_q != IDLE);

endmodule

// File: tb/tb_alu_slice_sched.sv
// ----------------------------------------------------------------------------
// tb_alu_slice_sched
//   Directed bench for alu_slice_sched. A behavioural slice (add / xor / and)
//   answers slice_in combinationally. Stimulus pushes the hand-computed
//   response into a scoreboard queue at each accepted request; an independent
//   monitor pops and compares whenever a response handshake is seen.
// ----------------------------------------------------------------------------
module tb_alu_slice_sched;
    import alu_slice_pkg::*;

    localparam int NIBBLES = 4;
    localparam int OPW     = 3;
    localparam int W       = 4 * NIBBLES;

    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_XOR = 3'd1;

    typedef struct {
        logic         id;
        logic [W-1:0] result;
        logic         cout;
    } exp_t;

    logic               clk = 1'b0;
    logic               rst_n;
    logic [SLICE_W-1:0] slice_in;
    logic [4:0]         slice_out;
    logic               busy;

    int   n_tests = 0;
    int   n_fail  = 0;
    exp_t sb[$];
    logic grant_log[$];
    exp_t mon_e;

    alu_slice_sched_if #(.NIBBLES(NIBBLES), .OPW(OPW)) bus ();

    alu_slice_sched #(.NIBBLES(NIBBLES), .OPW(OPW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus.slave),
        .slice_in  (slice_in),
        .slice_out (slice_out),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Behavioural 4-bit slice
    logic [3:0] m_a, m_b;
    logic       m_cin;
    logic [2:0] m_op;
    always_comb begin
        m_a   = slice_in[SLICE_A_LSB +: 4];
        m_b   = slice_in[SLICE_B_LSB +: 4];
        m_cin = slice_in[SLICE_CIN_BIT];
        m_op  = slice_in[SLICE_OP_LSB +: 3];
        case (m_op)
            OP_ADD:  slice_out = {1'b0, m_a} + {1'b0, m_b} + {4'b0, m_cin};
            OP_XOR:  slice_out = {1'b0, m_a ^ m_b};
            default: slice_out = {1'b0, m_a & m_b};
        endcase
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Monitor: compares every response handshake against the scoreboard.
    always @(negedge clk) begin
        if (rst_n && bus.rsp_valid && bus.rsp_ready) begin
            if (sb.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL rsp_unexpected: got id %0d result %0h, expected no response",
                         bus.rsp_id, bus.rsp_result);
            end else begin
                mon_e = sb.pop_front();
                check("rsp_id",     {31'b0, bus.rsp_id},   {31'b0, mon_e.id});
                check("rsp_result", {16'b0, bus.rsp_result}, {16'b0, mon_e.result});
                check("rsp_cout",   {31'b0, bus.rsp_cout}, {31'b0, mon_e.cout});
            end
        end
    end

    task automatic present(input logic id, input logic [2:0] op, input logic [W-1:0] a,
                           input logic [W-1:0] b);
        if (id) begin
            bus.req1_op = op; bus.req1_a = a; bus.req1_b = b; bus.req1_valid = 1'b1;
        end else begin
            bus.req0_op = op; bus.req0_a = a; bus.req0_b = b; bus.req0_valid = 1'b1;
        end
    endtask

    task automatic retire(input logic id);
        if (id) bus.req1_valid = 1'b0;
        else    bus.req0_valid = 1'b0;
    endtask

    // Waits for ready (sampled at negedge), then returns just after the
    // handshake edge.
    task automatic await_accept(input logic id, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (id ? bus.req1_ready : bus.req0_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (ok) begin
            @(posedge clk);
        end else begin
            n_tests++;
            n_fail++;
            $display("FAIL accept_timeout: got no ready for requester %0d, expected ready", id);
        end
    endtask

    // Presents (caller is positioned just after a posedge), waits for the
    // handshake, logs expectation, leaves valid asserted.
    task automatic drive_op(input logic id, input logic [2:0] op, input logic [W-1:0] a,
                            input logic [W-1:0] b, input logic [W-1:0] er, input logic ec);
        bit ok;
        present(id, op, a, b);
        await_accept(id, ok);
        if (ok) begin
            sb.push_back('{id: id, result: er, cout: ec});
            grant_log.push_back(id);
        end
        #1;
    endtask

    // Single operation: returns negedges from handshake to first rsp_valid
    // and the carry-in seen on slice_in in each pass.
    task automatic run_op(input logic id, input logic [2:0] op, input logic [W-1:0] a,
                          input logic [W-1:0] b, input logic [W-1:0] er, input logic ec,
                          output int lat, output logic [3:0] cins);
        @(posedge clk);
        #1;
        drive_op(id, op, a, b, er, ec);
        retire(id);
        lat  = 0;
        cins = '0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            lat++;
            if (bus.rsp_valid) break;
            if (lat <= 4) cins[lat-1] = slice_in[SLICE_CIN_BIT];
        end
    endtask

    task automatic drain();
        bit done;
        done = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (sb.size() == 0 && !busy) begin
                done = 1'b1;
                break;
            end
        end
        if (!done) begin
            n_tests++;
            n_fail++;
            $display("FAIL drain_timeout: got %0d pending responses, expected 0", sb.size());
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, expected finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int         lat;
        logic [3:0] cins;
        logic       seen;
        logic       exp_order[4];

        bus.req0_valid = 1'b0; bus.req0_op = '0; bus.req0_a = '0; bus.req0_b = '0;
        bus.req1_valid = 1'b0; bus.req1_op = '0; bus.req1_a = '0; bus.req1_b = '0;
        bus.rsp_ready  = 1'b0;
        rst_n          = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // Reset state after 10 idle cycles
        repeat (10) @(negedge clk);
        check("rst_rsp_valid",  {31'b0, bus.rsp_valid},  32'd0);
        check("rst_rsp_id",     {31'b0, bus.rsp_id},     32'd0);
        check("rst_rsp_result", {16'b0, bus.rsp_result}, 32'd0);
        check("rst_rsp_cout",   {31'b0, bus.rsp_cout},   32'd0);
        check("rst_req0_ready", {31'b0, bus.req0_ready}, 32'd0);
        check("rst_req1_ready", {31'b0, bus.req1_ready}, 32'd0);
        check("rst_slice_in",   {16'b0, slice_in},       32'd0);
        check("rst_busy",       {31'b0, busy},           32'd0);

        bus.rsp_ready = 1'b1;

        // Requester 0: 00FF + 0001
        run_op(1'b0, OP_ADD, 16'h00FF, 16'h0001, 16'h0100, 1'b0, lat, cins);
        check("op1_latency", lat,            32'd5);
        check("op1_cins",    {28'b0, cins},  32'h6);
        drain();

        // Requester 1: FFFF + 0001, carry ripples through all passes
        run_op(1'b1, OP_ADD, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, lat, cins);
        check("op2_latency", lat,            32'd5);
        check("op2_cins",    {28'b0, cins},  32'hE);
        drain();

        // Both requesters valid continuously: expect 0,1,0,1
        grant_log.delete();
        @(posedge clk);
        #1;
        fork
            begin
                drive_op(1'b0, OP_ADD, 16'h1234, 16'h1111, 16'h2345, 1'b0);
                drive_op(1'b0, OP_XOR, 16'hA5A5, 16'h0F0F, 16'hAAAA, 1'b0);
                retire(1'b0);
            end
            begin
                drive_op(1'b1, OP_ADD, 16'h8000, 16'h8000, 16'h0000, 1'b1);
                drive_op(1'b1, OP_ADD, 16'h7FFF, 16'h0001, 16'h8000, 1'b0);
                retire(1'b1);
            end
        join
        drain();
        exp_order = '{1'b0, 1'b1, 1'b0, 1'b1};
        check("rr_count", grant_log.size(), 32'd4);
        for (int i = 0; i < 4; i++) begin
            if (i < grant_log.size())
                check($sformatf("rr_order_%0d", i), {31'b0, grant_log[i]}, {31'b0, exp_order[i]});
        end

        // Backpressure: hold rsp_ready low in RESP
        bus.rsp_ready = 1'b0;
        run_op(1'b0, OP_ADD, 16'hF0F0, 16'hF0F0, 16'hE1E0, 1'b1, lat, cins);
        check("bp_latency", lat, 32'd5);
        @(posedge clk);
        #1;
        present(1'b1, OP_ADD, 16'h0001, 16'h0002);
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            check("bp_rsp_valid",  {31'b0, bus.rsp_valid},  32'd1);
            check("bp_rsp_result", {16'b0, bus.rsp_result}, 32'hE1E0);
            check("bp_rsp_cout",   {31'b0, bus.rsp_cout},   32'd1);
            check("bp_rsp_id",     {31'b0, bus.rsp_id},     32'd0);
            check("bp_req0_ready", {31'b0, bus.req0_ready}, 32'd0);
            check("bp_req1_ready", {31'b0, bus.req1_ready}, 32'd0);
        end
        @(posedge clk);
        #1;
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        check("bp_hs_rsp_valid",  {31'b0, bus.rsp_valid},  32'd1);
        check("bp_hs_req1_ready", {31'b0, bus.req1_ready}, 32'd0);
        @(posedge clk);
        @(negedge clk);
        check("bp_idle_rsp_valid",  {31'b0, bus.rsp_valid},  32'd0);
        check("bp_idle_req1_ready", {31'b0, bus.req1_ready}, 32'd1);
        @(posedge clk);
        sb.push_back('{id: 1'b1, result: 16'h0003, cout: 1'b0});
        #1;
        retire(1'b1);
        drain();

        // Reset during pass 2 aborts the operation
        @(posedge clk);
        #1;
        begin
            bit ok;
            present(1'b0, OP_ADD, 16'h4321, 16'h1111);
            await_accept(1'b0, ok);
            #1;
            retire(1'b0);
        end
        repeat (3) @(negedge clk);
        check("abort_pass2_a",   {28'b0, slice_in[SLICE_A_LSB +: 4]}, 32'h3);
        check("abort_pass2_cin", {31'b0, slice_in[SLICE_CIN_BIT]},    32'd0);
        rst_n = 1'b0;
        #1;
        check("abort_busy",      {31'b0, busy},           32'd0);
        check("abort_slice_in",  {16'b0, slice_in},       32'd0);
        check("abort_rsp_valid", {31'b0, bus.rsp_valid},  32'd0);
        check("abort_req0_rdy",  {31'b0, bus.req0_ready}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        seen  = 1'b0;
        repeat (10) begin
            @(negedge clk);
            seen = seen | bus.rsp_valid;
        end
        check("abort_no_rsp", {31'b0, seen}, 32'd0);

        run_op(1'b1, OP_ADD, 16'h4321, 16'h1234, 16'h5555, 1'b0, lat, cins);
        check("post_abort_latency", lat, 32'd5);
        drain();

        check("sb_empty", sb.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
